// File: rtl/pipeline_stall_scheduler_if.sv
// ---------------------------------------------------------------------------
// pipeline_stall_scheduler_if
// Bundles the hazard/event inputs and the pipeline control outputs of the
// stall/flush sequencer.
//   master : scheduler side (receives hazard flags, drives enables/flushes)
//   slave  : pipeline side (drives hazard flags, receives enables/flushes)
// Signals:
//   load_use_hz, pop_jmp_hz, branch_taken, mem_busy, int_req : events
//   pc_en, if_id_en, id_ex_en          : register enables
//   if_id_flush, id_ex_flush           : NOP loads
//   bubble_sel                         : decode zero-control mux select
//   int_ack                            : 1-cycle pulse on INT entry
//   int_phase [1:0], state_o [1:0]     : sequencer status
//   stall_cnt [CNT_W-1:0]              : stall performance counter
// ---------------------------------------------------------------------------
interface pipeline_stall_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             load_use_hz;
  logic             pop_jmp_hz;
  logic             branch_taken;
  logic             mem_busy;
  logic             int_req;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             bubble_sel;
  logic             int_ack;
  logic [1:0]       int_phase;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  load_use_hz, pop_jmp_hz, branch_taken, mem_busy, int_req,
    output pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, bubble_sel,
           int_ack, int_phase, state_o, stall_cnt
  );

  modport slave (
    output load_use_hz, pop_jmp_hz, branch_taken, mem_busy, int_req,
    input  pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, bubble_sel,
           int_ack, int_phase, state_o, stall_cnt
  );
endinterface

// File: rtl/pipeline_stall_scheduler.sv
// ---------------------------------------------------------------------------
// pipeline_stall_scheduler
// Central stall/flush sequencer for a 5-stage pipeline. Resolves the per-cycle
// event priority (mem_busy > branch_taken > pop_jmp_hz > load_use_hz >
// int_req), drives PC / IF-ID / ID-EX enables, flushes and the bubble mux
// select, and runs a RUN/STALL/INT FSM for multi-cycle pop->JMP stalls and
// the interrupt-entry sequence.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active low (control outputs forced safe while low)
//   bus   : pipeline_stall_scheduler_if.master (events in, controls/status out)
// Parameters:
//   POP_STALL_CYCLES : total stall cycles for a pop->JMP hazard (>=1)
//   INT_SEQ_LEN      : interrupt-entry steps (1..4)
//   CNT_W            : stall counter width
// Build option:
//   STALL_PERF_CNT_EN : when defined, stall_cnt counts cycles with pc_en==0
//                       (saturating); otherwise stall_cnt is tied to 0.
// ---------------------------------------------------------------------------
module pipeline_stall_scheduler #(
  parameter int POP_STALL_CYCLES = 2,
  parameter int INT_SEQ_LEN      = 3,
  parameter int CNT_W            = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pipeline_stall_scheduler_if.master  bus
);

  // int_phase is a fixed 2-bit port, so the sequence cannot exceed 4 steps.
  generate
    if (INT_SEQ_LEN < 1 || INT_SEQ_LEN > 4) begin : g_bad_int_len
      $error("INT_SEQ_LEN must be in 1..4");
    end
    if (POP_STALL_CYCLES < 1) begin : g_bad_pop_len
      $error("POP_STALL_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_INT   = 2'd2
  } state_t;

  localparam int REM_W = (POP_STALL_CYCLES > 2) ? $clog2(POP_STALL_CYCLES) : 1;
  // RUN cycle that sees the hazard is the first stall cycle; STALL covers the rest.
  localparam logic [REM_W-1:0] REM_INIT =
    (POP_STALL_CYCLES > 1) ? REM_W'(POP_STALL_CYCLES - 2) : '0;
  localparam logic [1:0] PHASE_LAST = 2'(INT_SEQ_LEN - 1);

  state_t           r_state,  w_next_state;
  logic [REM_W-1:0] r_rem,    w_next_rem;
  logic [1:0]       r_phase,  w_next_phase;
  logic             r_int_ack;
  logic             w_int_take;

  logic w_pc_en, w_if_id_en, w_id_ex_en;
  logic w_if_id_flush, w_id_ex_flush, w_bubble_sel;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_rem     <= '0;
      r_phase   <= '0;
      r_int_ack <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_rem     <= w_next_rem;
      r_phase   <= w_next_phase;
      r_int_ack <= w_int_take;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and control outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state  = r_state;
    w_next_rem    = r_rem;
    w_next_phase  = r_phase;
    w_int_take    = 1'b0;
    w_pc_en       = 1'b1;
    w_if_id_en    = 1'b1;
    w_id_ex_en    = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_bubble_sel  = 1'b0;

    if (!rst_n) begin
      // Safe pipeline while reset is held: nothing advances, NOPs everywhere.
      w_pc_en       = 1'b0;
      w_if_id_en    = 1'b0;
      w_id_ex_en    = 1'b0;
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      w_bubble_sel  = 1'b1;
    end else if (bus.mem_busy) begin
      // Full freeze: sequencer state holds via the defaults above.
      w_pc_en    = 1'b0;
      w_if_id_en = 1'b0;
      w_id_ex_en = 1'b0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (bus.branch_taken) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (bus.pop_jmp_hz) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
            w_bubble_sel  = 1'b1;
            if (POP_STALL_CYCLES > 1) begin
              w_next_state = ST_STALL;
              w_next_rem   = REM_INIT;
            end
          end else if (bus.load_use_hz) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
            w_bubble_sel  = 1'b1;
          end else if (bus.int_req) begin
            w_next_state = ST_INT;
            w_next_phase = 2'd0;
            w_int_take   = 1'b1;
          end
        end

        ST_STALL: begin
          if (bus.branch_taken) begin
            // Redirect makes the held JMP moot; flush and resume.
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_next_state  = ST_RUN;
            w_next_rem    = '0;
          end else begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
            w_bubble_sel  = 1'b1;
            if (r_rem == '0) w_next_state = ST_RUN;
            else             w_next_rem   = r_rem - 1'b1;
          end
        end

        ST_INT: begin
          // ID/EX keeps moving so the push/vector micro-ops issue.
          w_pc_en       = 1'b0;
          w_if_id_en    = 1'b0;
          w_if_id_flush = 1'b1;
          if (r_phase == PHASE_LAST) begin
            w_next_state = ST_RUN;
            w_next_phase = 2'd0;
          end else begin
            w_next_phase = r_phase + 2'd1;
          end
        end

        default: begin
          w_next_state = ST_RUN;
          w_next_rem   = '0;
          w_next_phase = 2'd0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Stall performance counter (counts every pc_en==0 cycle out of reset,
  // including memory freezes)
  // -------------------------------------------------------------------------
`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n)                              r_stall_cnt <= '0;
    else if (!w_pc_en && r_stall_cnt != '1)  r_stall_cnt <= r_stall_cnt + 1'b1;
  end
  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.stall_cnt = '0;
`endif

  assign bus.pc_en       = w_pc_en;
  assign bus.if_id_en    = w_if_id_en;
  assign bus.id_ex_en    = w_id_ex_en;
  assign bus.if_id_flush = w_if_id_flush;
  assign bus.id_ex_flush = w_id_ex_flush;
  assign bus.bubble_sel  = w_bubble_sel;
  assign bus.int_ack     = r_int_ack;
  assign bus.int_phase   = r_phase;
  assign bus.state_o     = r_state;

endmodule

// File: tb/tb_pipeline_stall_scheduler.sv
// Directed bench for pipeline_stall_scheduler (POP_STALL_CYCLES=2, INT_SEQ_LEN=3).
// Inputs change just after the falling edge; outputs are sampled 1ns later,
// so each step observes one full pipeline cycle.
module tb_pipeline_stall_scheduler;
  localparam int CNT_W = 16;
`ifdef STALL_PERF_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_stall_scheduler_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_scheduler #(
    .POP_STALL_CYCLES(2),
    .INT_SEQ_LEN(3),
    .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs {mem,br,pop,lu,irq} and settle.
  task automatic step(input logic rs, input logic [4:0] ev);
    @(negedge clk);
    rst_n            = rs;
    bus.mem_busy     = ev[4];
    bus.branch_taken = ev[3];
    bus.pop_jmp_hz   = ev[2];
    bus.load_use_hz  = ev[1];
    bus.int_req      = ev[0];
    #1;
  endtask

  // Compact check of {pc_en,if_id_en,id_ex_en,if_id_flush,id_ex_flush,bubble_sel}
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, bus.pc_en, bus.if_id_en, bus.id_ex_en,
              bus.if_id_flush, bus.id_ex_flush, bus.bubble_sel}, {26'd0, exp});
  endtask

  task automatic chk_st(input string tag, input logic [1:0] st, input logic ack,
                        input logic [1:0] ph);
    chk(tag, {27'd0, bus.state_o, bus.int_ack, bus.int_phase}, {27'd0, st, ack, ph});
  endtask

  initial begin
    bus.mem_busy = 0; bus.branch_taken = 0; bus.pop_jmp_hz = 0;
    bus.load_use_hz = 0; bus.int_req = 0; rst_n = 0;

    // Reset
    step(0, 5'b00000); chk_ctl("rst_forced", 6'b000111);
    step(0, 5'b00000); chk_ctl("rst_forced2", 6'b000111);
    chk_st("rst_state", 2'd0, 0, 2'd0);
    chk("rst_cnt", 32'(bus.stall_cnt), 32'd0);

    // Clean RUN
    step(1, 5'b00000); chk_ctl("run_idle", 6'b111000);

    // Load-use one cycle
    step(1, 5'b00010); chk_ctl("lu_stall", 6'b001011); chk_st("lu_state", 2'd0, 0, 2'd0);
    step(1, 5'b00000); chk_ctl("lu_after", 6'b111000);
    chk("lu_cnt", 32'(bus.stall_cnt), 32'(CNT_ON));

    // pop->JMP: two stall cycles, state 0->1->0
    step(1, 5'b00100); chk_ctl("pop_c0", 6'b001011); chk_st("pop_st0", 2'd0, 0, 2'd0);
    step(1, 5'b00000); chk_ctl("pop_c1", 6'b001011); chk_st("pop_st1", 2'd1, 0, 2'd0);
    step(1, 5'b00000); chk_ctl("pop_c2", 6'b111000); chk_st("pop_st2", 2'd0, 0, 2'd0);
    chk("pop_cnt", 32'(bus.stall_cnt), 32'(3 * CNT_ON));

    // Branch wins over load-use
    step(1, 5'b01010); chk_ctl("br_lu", 6'b111110); chk_st("br_lu_st", 2'd0, 0, 2'd0);

    // Interrupt with mem_busy freeze in phase 1
    step(1, 5'b00001); chk_ctl("irq_c0", 6'b111000); chk_st("irq_st0", 2'd0, 0, 2'd0);
    step(1, 5'b00000); chk_ctl("int_ph0", 6'b001100); chk_st("int_st0", 2'd2, 1, 2'd0);
    step(1, 5'b10000); chk_ctl("int_busy", 6'b000000); chk_st("int_busy_st", 2'd2, 0, 2'd1);
    for (int i = 0; i < 3; i++) begin
      step(1, 5'b10000); chk_st("int_busy_hold", 2'd2, 0, 2'd1);
    end
    step(1, 5'b00000); chk_ctl("int_resume", 6'b001100); chk_st("int_res_st", 2'd2, 0, 2'd1);
    step(1, 5'b00000); chk_st("int_ph2", 2'd2, 0, 2'd2);
    step(1, 5'b00000); chk_st("int_done", 2'd0, 0, 2'd0); chk_ctl("int_done_ctl", 6'b111000);

    // int_req pending behind pop stall
    step(1, 5'b00101); chk_st("pend_d0", 2'd0, 0, 2'd0); chk_ctl("pend_d0_ctl", 6'b001011);
    step(1, 5'b00001); chk_st("pend_d1", 2'd1, 0, 2'd0);
    step(1, 5'b00001); chk_st("pend_d2", 2'd0, 0, 2'd0); chk_ctl("pend_d2_ctl", 6'b111000);
    step(1, 5'b00000); chk_st("pend_d3", 2'd2, 1, 2'd0);
    step(1, 5'b00000); chk_st("pend_d4", 2'd2, 0, 2'd1);
    step(1, 5'b00000); chk_st("pend_d5", 2'd2, 0, 2'd2);
    step(1, 5'b00000); chk_st("pend_d6", 2'd0, 0, 2'd0);

    // Reset during INT phase 1 abandons the sequence
    step(1, 5'b00001);
    step(1, 5'b00000); chk_st("rint_ph0", 2'd2, 1, 2'd0);
    step(0, 5'b00000); chk_st("rint_ph1", 2'd2, 0, 2'd1); chk_ctl("rint_forced", 6'b000111);
    step(1, 5'b00000); chk_st("rint_after", 2'd0, 0, 2'd0); chk_ctl("rint_run", 6'b111000);
    chk("rint_cnt", 32'(bus.stall_cnt), 32'd0);
    step(1, 5'b00000); chk_st("rint_noack", 2'd0, 0, 2'd0);

    // Branch inside STALL flushes and returns to RUN
    step(1, 5'b00100); chk_st("bst_f0", 2'd0, 0, 2'd0);
    step(1, 5'b01000); chk_st("bst_f1", 2'd1, 0, 2'd0); chk_ctl("bst_flush", 6'b111110);
    step(1, 5'b00000); chk_st("bst_f2", 2'd0, 0, 2'd0); chk_ctl("bst_run", 6'b111000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
